// File: rtl/vga_sync_rx_if.sv
// VGA receive bundle: transmitter syncs/colour in,
// recovered raster position and lock status out.
interface vga_sync_rx_if;
  logic       hsync_n;
  logic       vsync_n;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       pixel_valid;
  logic [5:0] rgb;
  logic       locked;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output hsync_n, vsync_n, r, g, b,
    input  hpos, vpos, pixel_valid, rgb,
    input  locked, frame_start, sync_err
  );

  modport slave (
    input  hsync_n, vsync_n, r, g, b,
    output hpos, vpos, pixel_valid, rgb,
    output locked, frame_start, sync_err
  );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: locks a local raster counter to incoming
// hsync/vsync and reports the position of each captured pixel.
module vga_sync_rx #(
  parameter int H_VIEW  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_VIEW  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input logic          clk,
  input logic          reset_n,
  vga_sync_rx_if.slave bus
);
  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_AL = 10'(H_VIEW + H_FRONT);
  localparam logic [9:0] V_AL = 10'(V_VIEW + V_FRONT);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VW = 10'(H_VIEW);
  localparam logic [9:0] V_VW = 10'(V_VIEW);
  localparam logic [10:0] WD_LIM = 11'(2 * H_TOTAL);

  typedef enum logic [2:0] {
    UNLOCKED, H_SEEK, V_HUNT, V_SEEK, LOCKED
  } state_t;

  state_t      st, st_n;
  logic        hs_q, vs_q, hs_p, vs_p;
  logic [5:0]  rgb_q, rgb_d;
  logic [9:0]  hc, vc, hc_inc, vc_inc, hc_n, vc_n;
  logic [10:0] wd;
  logic        h_edge, v_edge, h_on, v_on;
  logic        h_align, v_align, err_n, err, wd_exp;
  logic        lock, pv;

  // input stage; syncs idle high so release sees no edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= bus.hsync_n;
      vs_q  <= bus.vsync_n;
      hs_p  <= hs_q;
      vs_p  <= vs_q;
      rgb_q <= {bus.b, bus.g, bus.r};
    end
  end

  always_comb begin
    h_edge  = hs_p & ~hs_q;
    v_edge  = vs_p & ~vs_q;
    hc_inc  = (hc == H_MAX) ? '0 : hc + 10'd1;
    h_on    = (hc_inc == H_AL);
    st_n    = st;
    err_n   = 1'b0;
    h_align = 1'b0;
    v_align = 1'b0;
    if (h_edge) begin
      unique case (st)
        UNLOCKED: begin
          h_align = 1'b1;
          st_n    = H_SEEK;
        end
        H_SEEK: begin
          if (h_on) st_n = V_HUNT;
          else h_align = 1'b1;
        end
        default: begin
          if (!h_on) begin
            h_align = 1'b1;
            err_n   = (st == V_SEEK) || (st == LOCKED);
            st_n    = H_SEEK;
          end
        end
      endcase
    end
    hc_n   = h_align ? H_AL : hc_inc;
    vc_inc = vc;
    if (!h_align && hc == H_MAX)
      vc_inc = (vc == V_MAX) ? '0 : vc + 10'd1;
    v_on = (vc_inc == V_AL);
    // vsync rule sees the state left by the hsync rule
    if (v_edge) begin
      unique case (st_n)
        V_HUNT: begin
          v_align = 1'b1;
          st_n    = V_SEEK;
        end
        V_SEEK: begin
          if (v_on) st_n = LOCKED;
          else begin
            v_align = 1'b1;
            err_n   = 1'b1;
          end
        end
        LOCKED: begin
          if (!v_on) begin
            v_align = 1'b1;
            err_n   = 1'b1;
            st_n    = V_SEEK;
          end
        end
        default: ;
      endcase
    end
    vc_n   = v_align ? V_AL : vc_inc;
    wd_exp = !h_edge && (wd == WD_LIM - 11'd1);
    if (wd_exp) begin
      st_n  = UNLOCKED;
      err_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= UNLOCKED;
      hc    <= '0;
      vc    <= '0;
      wd    <= '0;
      err   <= 1'b0;
      rgb_d <= '0;
    end else begin
      st    <= st_n;
      hc    <= hc_n;
      vc    <= vc_n;
      err   <= err_n;
      rgb_d <= rgb_q;
      if (h_edge) wd <= '0;
      else if (wd != WD_LIM) wd <= wd + 11'd1;
    end
  end

  assign lock = (st == LOCKED);
  assign pv   = lock && (hc < H_VW) && (vc < V_VW);

  assign bus.hpos        = hc;
  assign bus.vpos        = vc;
  assign bus.locked      = lock;
  assign bus.pixel_valid = pv;
  assign bus.rgb         = pv ? rgb_d : '0;
  assign bus.frame_start = lock && (hc == '0) && (vc == '0);
  assign bus.sync_err    = err;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a reduced 32x16 raster driven
// by a behavioural VGA source with fault injection.
module tb_vga_sync_rx;
  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8, VF = 2, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HA = HV + HF;
  localparam int VA = VV + VF;
  localparam int FRAME = HT * VT;

  typedef struct {
    int         x;
    int         y;
    logic       pv;
    logic       fs;
    logic [5:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  vga_sync_rx_if bus();

  vga_sync_rx #(
    .H_VIEW(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VIEW(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sx = 0, sy = 0;
  int px = -1, py = -1;
  int cx = -1, cy = -1;
  bit src_on = 0, h_early = 0, h_mask = 0, v_early = 0;

  function automatic logic [5:0] colour(input int x, input int y);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    return {xv[3:2], yv[1:0], xv[1:0]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // drive one sample, clock it, then cx/cy name the sample on the outputs
  task automatic step();
    logic hs, vs;
    logic [5:0] c;
    hs = 1'b1;
    vs = 1'b1;
    c = colour(sx, sy);
    if (src_on) begin
      hs = !(sx >= HA && sx < HA + HS);
      vs = !(sy >= VA && sy < VA + VS);
      if (h_early && sx == HA - 1) begin
        hs = 1'b0;
        h_early = 0;
      end
      if (h_mask) hs = 1'b1;
      if (v_early && sy == VA - 1) vs = 1'b0;
      if (v_early && sy == VA) v_early = 0;
    end
    bus.hsync_n = hs;
    bus.vsync_n = vs;
    bus.r = c[1:0];
    bus.g = c[3:2];
    bus.b = c[5:4];
    @(posedge clk);
    #1;
    cx = px;
    cy = py;
    px = sx;
    py = sy;
    sx++;
    if (sx == HT) begin
      sx = 0;
      sy = (sy == VT - 1) ? 0 : sy + 1;
    end
  endtask

  task automatic seek_cur(input int x, input int y, input string nm);
    int k;
    k = 0;
    while (!(cx == x && cy == y) && k < 2 * FRAME) begin
      step();
      k++;
    end
    chk({nm, " reached"}, int'(cx == x && cy == y), 1);
  endtask

  task automatic seek_next(input int x, input int y, input string nm);
    int k;
    k = 0;
    while (!(sx == x && sy == y) && k < 2 * FRAME) begin
      step();
      k++;
    end
    chk({nm, " reached"}, int'(sx == x && sy == y), 1);
  endtask

  task automatic wait_lock(input string nm, input int exp_vs,
                           input int exp_err);
    int vs_seen, errs;
    bit done;
    vs_seen = 0;
    errs = 0;
    done = 0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      step();
      if (cx == 0 && cy == VA) vs_seen++;
      if (bus.sync_err) errs++;
      if (bus.locked) done = 1;
    end
    chk({nm, " lock reached"}, int'(done), 1);
    if (done && exp_vs >= 0) begin
      chk({nm, " lock hpos"}, int'(bus.hpos), 0);
      chk({nm, " lock vpos"}, int'(bus.vpos), VA);
      chk({nm, " vsync count"}, vs_seen, exp_vs);
      chk({nm, " sync_err count"}, errs, exp_err);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " hpos"}, int'(bus.hpos), 0);
    chk({nm, " vpos"}, int'(bus.vpos), 0);
    chk({nm, " pixel_valid"}, int'(bus.pixel_valid), 0);
    chk({nm, " rgb"}, int'(bus.rgb), 0);
    chk({nm, " locked"}, int'(bus.locked), 0);
    chk({nm, " frame_start"}, int'(bus.frame_start), 0);
    chk({nm, " sync_err"}, int'(bus.sync_err), 0);
  endtask

  initial begin
    vec_t tbl[6];
    int bad, fs_cnt, wd_drop, wd_err;
    logic pv;

    tbl[0] = '{0, 0, 1'b1, 1'b1, 6'd0};
    tbl[1] = '{5, 3, 1'b1, 1'b0, 6'd29};
    tbl[2] = '{15, 7, 1'b1, 1'b0, 6'd63};
    tbl[3] = '{16, 7, 1'b0, 1'b0, 6'd0};
    tbl[4] = '{15, 8, 1'b0, 1'b0, 6'd0};
    tbl[5] = '{31, 15, 1'b0, 1'b0, 6'd0};

    bus.hsync_n = 1'b1;
    bus.vsync_n = 1'b1;
    bus.r = 2'd3;
    bus.g = 2'd3;
    bus.b = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.locked || bus.sync_err) bad++;
    end
    chk("idle lock/err", bad, 0);

    src_on = 1;
    sx = 0;
    sy = 0;
    wait_lock("initial", 2, 0);

    fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      pv = (cx < HV) && (cy < VV);
      chk("frame hpos", int'(bus.hpos), cx);
      chk("frame vpos", int'(bus.vpos), cy);
      chk("frame pixel_valid", int'(bus.pixel_valid), int'(pv));
      chk("frame rgb", int'(bus.rgb), pv ? int'(colour(cx, cy)) : 0);
      chk("frame frame_start", int'(bus.frame_start),
          int'(cx == 0 && cy == 0));
      chk("frame locked", int'(bus.locked), 1);
      chk("frame sync_err", int'(bus.sync_err), 0);
      if (bus.frame_start) fs_cnt++;
    end
    chk("frame_start per frame", fs_cnt, 1);

    for (int i = 0; i < 6; i++) begin
      seek_cur(tbl[i].x, tbl[i].y, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d hpos", i), int'(bus.hpos), tbl[i].x);
      chk($sformatf("tbl%0d vpos", i), int'(bus.vpos), tbl[i].y);
      chk($sformatf("tbl%0d pixel_valid", i),
          int'(bus.pixel_valid), int'(tbl[i].pv));
      chk($sformatf("tbl%0d frame_start", i),
          int'(bus.frame_start), int'(tbl[i].fs));
      chk($sformatf("tbl%0d rgb", i), int'(bus.rgb), int'(tbl[i].rgb));
    end

    // hsync one clock early on line 2
    seek_next(0, 2, "h_early setup");
    h_early = 1;
    seek_cur(HA - 1, 2, "h_early edge");
    chk("h_early sync_err", int'(bus.sync_err), 1);
    chk("h_early locked", int'(bus.locked), 0);
    chk("h_early hpos", int'(bus.hpos), HA);
    chk("h_early vpos", int'(bus.vpos), 2);
    step();
    chk("h_early err pulse width", int'(bus.sync_err), 0);
    wait_lock("h_early relock", 2, 0);

    // missing hsync: watchdog
    seek_cur(HA, 1, "wd last edge");
    chk("wd locked at edge", int'(bus.locked), 1);
    h_mask = 1;
    wd_drop = 0;
    wd_err = 0;
    for (int n = 1; n <= 2 * HT; n++) begin
      step();
      if (bus.sync_err) wd_err++;
      if (n < 2 * HT && !bus.locked) wd_drop++;
    end
    chk("wd unlock at limit", int'(bus.locked), 0);
    chk("wd early unlock", wd_drop, 0);
    chk("wd sync_err", wd_err, 0);
    repeat (8) step();
    h_mask = 0;
    wait_lock("wd relock", -1, 0);

    // vsync one line early
    seek_next(0, VA - 1, "v_early setup");
    v_early = 1;
    seek_cur(0, VA - 1, "v_early edge");
    chk("v_early sync_err", int'(bus.sync_err), 1);
    chk("v_early locked", int'(bus.locked), 0);
    chk("v_early vpos", int'(bus.vpos), VA);
    chk("v_early hpos", int'(bus.hpos), 0);
    wait_lock("v_early relock", 3, 1);

    // reset mid-frame
    seek_cur(HV / 2, VV / 2, "mid reset");
    chk("mid reset locked before", int'(bus.locked), 1);
    reset_n = 1'b0;
    #2;
    chk_zero("mid reset");
    step();
    reset_n = 1'b1;
    wait_lock("mid reset relock", 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
